// File: rtl/pbus_burst_capture.sv
// Parallel-bus burst capture: stores up to DEPTH strobed words per request
// and exposes them through a registered random-access read port.
module pbus_burst_capture #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LENW  = $clog2(DEPTH + 1),
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  input  logic            abort,
  input  logic [DW-1:0]   din,
  input  logic            din_stb,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            aborted,
  output logic [LENW-1:0] count,
  output logic            dropped,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] len_nxt;
  logic [LENW-1:0] count_nxt;
  logic [LENW-1:0] cnt_inc;
  logic            dropped_nxt;
  logic            err_nxt;
  logic            aborted_nxt;
  logic            wr_en;
  logic            len_ok;
  logic            rd_in_range;

  logic [DW-1:0]   mem [DEPTH];

  assign cnt_inc = count + 1'b1;
  assign len_ok  = (len != '0) && (32'(len) <= DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    count_nxt   = count;
    dropped_nxt = dropped;
    err_nxt     = 1'b0;
    aborted_nxt = 1'b0;
    wr_en       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_nxt   = S_CAPTURE;
            len_nxt     = len;
            count_nxt   = '0;
            dropped_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        // Abort wins over a coincident strobe: nothing is written.
        if (abort) begin
          state_nxt   = S_IDLE;
          aborted_nxt = 1'b1;
        end else if (din_stb) begin
          wr_en     = 1'b1;
          count_nxt = cnt_inc;
          if (cnt_inc == len_q) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Applied after the start-clear so a strobe on the accepting cycle still sticks.
    if (din_stb && (state != S_CAPTURE)) dropped_nxt = 1'b1;
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      count   <= '0;
      dropped <= 1'b0;
      len_q   <= '0;
    end else begin
      busy    <= (state_nxt == S_CAPTURE);
      done    <= (state_nxt == S_DONE);
      err     <= err_nxt;
      aborted <= aborted_nxt;
      count   <= count_nxt;
      dropped <= dropped_nxt;
      len_q   <= len_nxt;
    end
  end

  // Capture buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[AW'(count)] <= din;
  end

  if ((1 << AW) > DEPTH) begin : g_oob
    assign rd_in_range = (32'(rd_addr) < DEPTH);
  end else begin : g_full
    assign rd_in_range = 1'b1;
  end

  // Read port: one-cycle latency, out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (rst)              rd_data <= '0;
    else if (rd_in_range) rd_data <= mem[rd_addr];
    else                  rd_data <= '0;
  end

endmodule

// File: tb/tb_pbus_burst_capture.sv
// Scenario bench for pbus_burst_capture with a word-level buffer model.
module tb_pbus_burst_capture;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LENW  = 5;
  localparam int unsigned AW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LENW-1:0] len;
  logic            abort;
  logic [DW-1:0]   din;
  logic            din_stb;
  logic            busy;
  logic            done;
  logic            err;
  logic            aborted;
  logic [LENW-1:0] count;
  logic            dropped;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;

  int total = 0;
  int bad   = 0;

  // Model: what each buffer entry should hold, and what count should read.
  logic [DW-1:0] mmem [DEPTH];
  int            mcount;

  pbus_burst_capture #(.DW(DW), .DEPTH(DEPTH), .LENW(LENW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .din(din), .din_stb(din_stb), .busy(busy), .done(done), .err(err),
    .aborted(aborted), .count(count), .dropped(dropped),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input int a, output logic [DW-1:0] d);
    rd_addr = AW'(a);
    step();
    d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    din = '0; din_stb = 1'b0; rd_addr = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({busy, done, err, aborted, dropped} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {busy, done, err, aborted, dropped});
    end
    total++;
    if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    mcount = 0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    int done_seen = 0;
    start = 1'b1; len = 5'd4;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || count !== '0) begin
      bad++; $display("FAIL basic_start busy=%b count=%0d want busy=1 count=0", busy, count);
    end
    for (int i = 0; i < 4; i++) begin
      din = DW'(i + 1); din_stb = 1'b1;
      step();
      din_stb = 1'b0;
      mmem[i] = DW'(i + 1);
      if (done) done_seen++;
      total++;
      if (count !== LENW'(i + 1)) begin
        bad++; $display("FAIL basic_count[%0d] got=%0d want=%0d", i, count, i + 1);
      end
      // Gap cycle; a start with bad length here must be ignored (no err).
      start = (i == 0); len = '0;
      step();
      start = 1'b0;
      if (done) done_seen++;
      if (i == 0) begin
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL basic_start_in_capture err=%b want=0", err); end
      end
      if (i == 3) begin
        // This sample is DONE->IDLE; start presented in DONE cycle just below.
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
      end
    end
    total++;
    if (done_seen !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_seen); end
    mcount = 4;
    for (int i = 0; i < 4; i++) begin
      read_word(i, d);
      total++;
      if (d !== mmem[i]) begin bad++; $display("FAIL basic_read[%0d] got=%h want=%h", i, d, mmem[i]); end
    end
  endtask

  task automatic test_done_ignores_start();
    start = 1'b1; len = 5'd1;
    step();
    start = 1'b0;
    din = 32'hA5A5_0001; din_stb = 1'b1;
    step();
    din_stb = 1'b0;
    mmem[0] = 32'hA5A5_0001; mcount = 1;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 5'd1) begin
      bad++; $display("FAIL len1_done done=%b busy=%b count=%0d want 1 0 1", done, busy, count);
    end
    start = 1'b1; len = 5'd3;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL start_in_done busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    int busy_cycles = 0;
    start = 1'b1; len = LENW'(DEPTH);
    step();
    start = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (busy) busy_cycles++;
      din = DW'(i); din_stb = 1'b1;
      step();
      mmem[i] = DW'(i);
    end
    din_stb = 1'b0;
    mcount = DEPTH;
    total++;
    if (busy_cycles !== int'(DEPTH)) begin
      bad++; $display("FAIL full_busy_cycles got=%0d want=%0d", busy_cycles, DEPTH);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== LENW'(DEPTH)) begin
      bad++; $display("FAIL full_done done=%b busy=%b count=%0d want 1 0 %0d", done, busy, count, DEPTH);
    end
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL full_done_width got=%b want=0", done); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      read_word(i, d);
      total++;
      if (d !== mmem[i]) begin bad++; $display("FAIL full_read[%0d] got=%h want=%h", i, d, mmem[i]); end
    end
  endtask

  task automatic test_err();
    logic [LENW-1:0] bad_len [2];
    bad_len[0] = '0;
    bad_len[1] = LENW'(DEPTH + 1);
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; len = bad_len[k]; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0) begin
        bad++; $display("FAIL err_pulse[%0d] err=%b busy=%b aborted=%b want 1 0 0", k, err, busy, aborted);
      end
      total++;
      if (count !== LENW'(mcount)) begin
        bad++; $display("FAIL err_count[%0d] got=%0d want=%0d", k, count, mcount);
      end
      step();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL err_clear[%0d] err=%b busy=%b want 0 0", k, err, busy);
      end
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] d;
    start = 1'b1; len = 5'd8;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom; din_stb = 1'b1;
      mmem[i] = din;
      step();
    end
    din = ~mmem[3]; din_stb = 1'b1; abort = 1'b1;
    step();
    din_stb = 1'b0; abort = 1'b0;
    mcount = 3;
    total++;
    if (aborted !== 1'b1 || count !== 5'd3 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_pulse aborted=%b count=%0d busy=%b done=%b want 1 3 0 0",
                      aborted, count, busy, done);
    end
    step();
    total++;
    if (aborted !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_after aborted=%b done=%b want 0 0", aborted, done);
    end
    for (int i = 0; i < 4; i++) begin
      read_word(i, d);
      total++;
      if (d !== mmem[i]) begin bad++; $display("FAIL abort_read[%0d] got=%h want=%h", i, d, mmem[i]); end
    end
  endtask

  task automatic test_dropped();
    logic [DW-1:0] d;
    din = ~mmem[3]; din_stb = 1'b1;
    step();
    din_stb = 1'b0;
    total++;
    if (dropped !== 1'b1) begin bad++; $display("FAIL drop_idle got=%b want=1", dropped); end
    start = 1'b1; len = 5'd2; din = ~mmem[0]; din_stb = 1'b1;
    step();
    start = 1'b0; din_stb = 1'b0;
    total++;
    if (dropped !== 1'b1 || busy !== 1'b1 || count !== '0) begin
      bad++; $display("FAIL drop_on_start dropped=%b busy=%b count=%0d want 1 1 0", dropped, busy, count);
    end
    for (int i = 0; i < 2; i++) begin
      din = $urandom; din_stb = 1'b1;
      mmem[i] = din;
      step();
    end
    din_stb = 1'b0;
    mcount = 2;
    total++;
    if (done !== 1'b1 || count !== 5'd2) begin
      bad++; $display("FAIL drop_burst done=%b count=%0d want 1 2", done, count);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      read_word(i, d);
      total++;
      if (d !== mmem[i]) begin bad++; $display("FAIL drop_read[%0d] got=%h want=%h", i, d, mmem[i]); end
    end
    start = 1'b1; len = 5'd1;
    step();
    start = 1'b0;
    total++;
    if (dropped !== 1'b0) begin bad++; $display("FAIL drop_clear got=%b want=0", dropped); end
    din = $urandom; din_stb = 1'b1;
    mmem[0] = din;
    step();
    din_stb = 1'b0;
    mcount = 1;
    step();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    start = 1'b1; len = 5'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = $urandom; din_stb = 1'b1;
      mmem[i] = din;
      step();
    end
    din = $urandom; din_stb = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; din_stb = 1'b0;
    mcount = 0;
    total++;
    if ({busy, done, err, aborted, dropped} !== 5'b0 || count !== '0) begin
      bad++; $display("FAIL rst_mid flags=%b count=%0d want 00000 0", {busy, done, err, aborted, dropped}, count);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after done=%b busy=%b want 0 0", done, busy);
    end
    start = 1'b1; len = 5'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = $urandom; din_stb = 1'b1;
      mmem[i] = din;
      step();
    end
    din_stb = 1'b0;
    mcount = 2;
    total++;
    if (done !== 1'b1 || count !== 5'd2) begin
      bad++; $display("FAIL rst_then_burst done=%b count=%0d want 1 2", done, count);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      read_word(i, d);
      total++;
      if (d !== mmem[i]) begin bad++; $display("FAIL rst_read[%0d] got=%h want=%h", i, d, mmem[i]); end
    end
  endtask

  task automatic test_random_bursts();
    logic [DW-1:0] d;
    for (int b = 0; b < 12; b++) begin
      int l;
      int done_seen;
      int gap;
      l = $urandom_range(int'(DEPTH), 1);
      done_seen = 0;
      start = 1'b1; len = LENW'(l);
      step();
      start = 1'b0;
      for (int i = 0; i < l; i++) begin
        gap = $urandom_range(2, 0);
        for (int g = 0; g < gap; g++) begin
          step();
          if (done) done_seen++;
        end
        din = $urandom; din_stb = 1'b1;
        mmem[i] = din;
        step();
        din_stb = 1'b0;
        if (done) done_seen++;
      end
      total++;
      if (done !== 1'b1 || count !== LENW'(l) || busy !== 1'b0) begin
        bad++; $display("FAIL rnd_done[%0d] done=%b count=%0d busy=%b want 1 %0d 0", b, done, count, busy, l);
      end
      step();
      total++;
      if (done_seen !== 1 || done !== 1'b0) begin
        bad++; $display("FAIL rnd_pulses[%0d] seen=%0d done=%b want 1 0", b, done_seen, done);
      end
      mcount = l;
      for (int r = 0; r < 4; r++) begin
        int a;
        a = $urandom_range(int'(DEPTH) - 1, 0);
        read_word(a, d);
        total++;
        if (d !== mmem[a]) begin bad++; $display("FAIL rnd_read[%0d] addr=%0d got=%h want=%h", b, a, d, mmem[a]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_ignores_start();
    test_full();
    test_err();
    test_abort();
    test_dropped();
    test_reset_mid();
    test_random_bursts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
